// File: rtl/traffic_sensor_frontend.sv
// Loop-detector front end: synchronizes eight raw loop inputs, debounces them into
// qualified occupancy for the light controller, and flags loops that stay stuck high.
module traffic_sensor_frontend #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned HOLD     = 8,
  parameter int unsigned STUCK    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] loop_1th_raw,
  input  logic [3:0] loop_5th_raw,
  input  logic       fault_clr,
  output logic [3:0] sensor_1th,
  output logic [3:0] sensor_5th,
  output logic [3:0] fault_1th,
  output logic [3:0] fault_5th
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_OCC,
    S_REL,
    S_STUCK
  } state_t;

  localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD - 1);
  localparam logic [15:0] STUCK_LAST = 16'(STUCK - 1);

  logic [7:0]  raw;
  logic [7:0]  sync_a;
  logic [7:0]  sync_b;
  state_t      state     [8];
  state_t      state_nxt [8];
  logic [15:0] cnt       [8];
  logic [15:0] cnt_nxt   [8];
  logic [7:0]  occ_nxt;
  logic [7:0]  enter_stuck;
  logic [7:0]  sensor_q;
  logic [7:0]  fault_q;

  // Channels 0-3 are first-car loops, 4-7 fifth-car loops.
  assign raw = {loop_5th_raw, loop_1th_raw};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  always_comb begin
    occ_nxt     = '0;
    enter_stuck = '0;
    for (int i = 0; i < 8; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        S_IDLE: begin
          if (sync_b[i]) begin
            if (DEBOUNCE == 1) begin
              state_nxt[i] = S_OCC;
              cnt_nxt[i]   = '0;
            end else begin
              state_nxt[i] = S_ARM;
              cnt_nxt[i]   = 16'd1;
            end
          end else begin
            cnt_nxt[i] = '0;
          end
        end
        S_ARM: begin
          if (!sync_b[i]) begin
            state_nxt[i] = S_IDLE;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == DEB_LAST) begin
            state_nxt[i] = S_OCC;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + 16'd1;
          end
        end
        S_OCC: begin
          if (!sync_b[i]) begin
            if (HOLD == 1) begin
              state_nxt[i] = S_IDLE;
              cnt_nxt[i]   = '0;
            end else begin
              state_nxt[i] = S_REL;
              cnt_nxt[i]   = 16'd1;
            end
          end else if (cnt[i] == STUCK_LAST) begin
            state_nxt[i] = S_STUCK;
          end else begin
            cnt_nxt[i] = cnt[i] + 16'd1;
          end
        end
        S_REL: begin
          if (sync_b[i]) begin
            state_nxt[i] = S_OCC;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == HOLD_LAST) begin
            state_nxt[i] = S_IDLE;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + 16'd1;
          end
        end
        S_STUCK: begin
          if (!sync_b[i]) begin
            state_nxt[i] = S_IDLE;
            cnt_nxt[i]   = '0;
          end
        end
        default: begin
          state_nxt[i] = S_IDLE;
          cnt_nxt[i]   = '0;
        end
      endcase
      occ_nxt[i]     = (state_nxt[i] == S_OCC) || (state_nxt[i] == S_REL);
      enter_stuck[i] = (state_nxt[i] == S_STUCK) && (state[i] != S_STUCK);
    end
  end

  // Sensor and fault are registered from next state so they change on the same
  // edge as the state itself; a new stuck event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        state[i] <= S_IDLE;
        cnt[i]   <= '0;
      end
      sensor_q <= '0;
      fault_q  <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      sensor_q <= occ_nxt;
      fault_q  <= (fault_q & {8{~fault_clr}}) | enter_stuck;
    end
  end

  assign sensor_1th = sensor_q[3:0];
  assign sensor_5th = sensor_q[7:4];
  assign fault_1th  = fault_q[3:0];
  assign fault_5th  = fault_q[7:4];

endmodule

// File: tb/tb_traffic_sensor_frontend.sv
// Directed bench for traffic_sensor_frontend at default parameters: reset, qualify,
// glitch reject, gap/release, stuck detection with fault clear, and concurrency.
module tb_traffic_sensor_frontend;

  logic       clk;
  logic       rst;
  logic [3:0] loop_1th_raw;
  logic [3:0] loop_5th_raw;
  logic       fault_clr;
  logic [3:0] sensor_1th;
  logic [3:0] sensor_5th;
  logic [3:0] fault_1th;
  logic [3:0] fault_5th;

  int check_count = 0;
  int pass_count  = 0;
  logic seen;

  traffic_sensor_frontend dut (
    .clk          (clk),
    .rst          (rst),
    .loop_1th_raw (loop_1th_raw),
    .loop_5th_raw (loop_5th_raw),
    .fault_clr    (fault_clr),
    .sensor_1th   (sensor_1th),
    .sensor_5th   (sensor_5th),
    .fault_1th    (fault_1th),
    .fault_5th    (fault_5th)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [3:0] l1, input logic [3:0] l5);
    @(negedge clk);
    loop_1th_raw = l1;
    loop_5th_raw = l5;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [3:0] s1, input logic [3:0] s5,
                          input logic [3:0] f1, input logic [3:0] f5);
    checkOutput({tag, ".sensor_1th"}, sensor_1th, s1);
    checkOutput({tag, ".sensor_5th"}, sensor_5th, s5);
    checkOutput({tag, ".fault_1th"},  fault_1th,  f1);
    checkOutput({tag, ".fault_5th"},  fault_5th,  f5);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d/%0d checks passed", pass_count, check_count + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    loop_1th_raw = 4'b1111;
    loop_5th_raw = 4'b0000;
    fault_clr    = 1'b0;

    // Asynchronous reset with raw inputs high, then held through several clocks
    #2 rst = 1'b0;
    #1 checkAll("reset_async", 4'b0, 4'b0, 4'b0, 4'b0);
    waitEdges(8);
    checkAll("reset_held", 4'b0, 4'b0, 4'b0, 4'b0);
    @(negedge clk);
    loop_1th_raw = 4'b0000;
    rst = 1'b1;
    waitEdges(4);

    // Qualify: sensor_1th[0] rises after edge 6
    applyStimulus(4'b0001, 4'b0000);
    waitEdges(5);
    checkOutput("qualify_edge5", sensor_1th, 4'b0000);
    waitEdges(1);
    checkAll("qualify_edge6", 4'b0001, 4'b0000, 4'b0000, 4'b0000);

    // Gap of 5 low cycles does not drop occupancy
    applyStimulus(4'b0000, 4'b0000);
    waitEdges(5);
    checkOutput("gap_low5", sensor_1th, 4'b0001);
    applyStimulus(4'b0001, 4'b0000);
    waitEdges(3);
    checkOutput("gap_refill3", sensor_1th, 4'b0001);
    waitEdges(7);
    checkOutput("gap_refill10", sensor_1th, 4'b0001);

    // Release: sensor falls after edge 10
    applyStimulus(4'b0000, 4'b0000);
    waitEdges(9);
    checkOutput("release_edge9", sensor_1th, 4'b0001);
    waitEdges(1);
    checkOutput("release_edge10", sensor_1th, 4'b0000);

    // Glitch: three high cycles on loop_5th_raw[2] never qualify
    seen = 1'b0;
    applyStimulus(4'b0000, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      waitEdges(1);
      seen = seen | sensor_5th[2];
    end
    applyStimulus(4'b0000, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      waitEdges(1);
      seen = seen | sensor_5th[2];
    end
    checkOutput("glitch_reject", {3'b000, seen}, 4'b0000);

    // Stuck detector on loop_5th_raw[3]
    applyStimulus(4'b0000, 4'b1000);
    waitEdges(5);
    checkOutput("stuck_edge5", sensor_5th, 4'b0000);
    waitEdges(1);
    checkAll("stuck_edge6", 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    waitEdges(999);
    checkAll("stuck_edge1005", 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    waitEdges(1);
    checkAll("stuck_edge1006", 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    applyStimulus(4'b0000, 4'b0000);
    waitEdges(5);
    checkAll("stuck_released", 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    @(negedge clk);
    fault_clr = 1'b1;
    waitEdges(1);
    fault_clr = 1'b0;
    checkOutput("fault_cleared", fault_5th, 4'b0000);

    // Concurrency across buses, then a reset pulse mid-run
    applyStimulus(4'b1100, 4'b1010);
    waitEdges(5);
    checkAll("conc_edge5", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    waitEdges(1);
    checkAll("conc_edge6", 4'b1100, 4'b1010, 4'b0000, 4'b0000);
    waitEdges(3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 checkAll("conc_reset_async", 4'b0, 4'b0, 4'b0, 4'b0);
    waitEdges(2);
    checkAll("conc_reset_held", 4'b0, 4'b0, 4'b0, 4'b0);
    @(negedge clk);
    rst = 1'b1;
    waitEdges(5);
    checkAll("requal_edge5", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    waitEdges(1);
    checkAll("requal_edge6", 4'b1100, 4'b1010, 4'b0000, 4'b0000);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
